// File: rtl/p4_router_egress_demux.sv
`default_nettype none
// p4_router_egress_demux: steers whole packets from the VNP4 egress AXIS bus to
// per-port one-deep output registers, dropping disabled or out-of-range packets.
module p4_router_egress_demux #(
  parameter int NUM_EGR_PHYS_PORTS = 4,
  parameter int DATA_BYTES         = 64,
  parameter int USER_WIDTH         = 8,
  parameter int EGR_COUNTERS_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [DATA_BYTES*8-1:0]         egr_bus_tdata,
  input  logic [DATA_BYTES-1:0]           egr_bus_tkeep,
  input  logic [USER_WIDTH-1:0]           egr_bus_tuser,
  input  logic                            egr_bus_tlast,
  input  logic                            egr_bus_tvalid,
  output logic                            egr_bus_tready,
  output logic [DATA_BYTES*8-1:0]         egr_ports_tdata [NUM_EGR_PHYS_PORTS],
  output logic [DATA_BYTES-1:0]           egr_ports_tkeep [NUM_EGR_PHYS_PORTS],
  output logic [NUM_EGR_PHYS_PORTS-1:0]   egr_ports_tlast,
  output logic [NUM_EGR_PHYS_PORTS-1:0]   egr_ports_tvalid,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]   egr_ports_tready,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]   egr_phys_ports_enable,
  input  logic [NUM_EGR_PHYS_PORTS-1:0]   egr_cnts_clear,
  output logic [EGR_COUNTERS_WIDTH-1:0]   egr_pkt_cnt [NUM_EGR_PHYS_PORTS],
  output logic [EGR_COUNTERS_WIDTH-1:0]   egr_drop_cnt [NUM_EGR_PHYS_PORTS],
  output logic [EGR_COUNTERS_WIDTH-1:0]   egr_bad_port_drop_cnt,
  input  logic                            egr_bad_port_clear
);

  localparam int N      = NUM_EGR_PHYS_PORTS;
  localparam int CW     = EGR_COUNTERS_WIDTH;
  localparam int PORT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PADW   = 1 << PORT_W;
  localparam logic [PORT_W:0] N_EXT   = (PORT_W + 1)'(N);
  localparam logic [CW-1:0]   CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [PORT_W-1:0] sel, idx, cur_sel;
  logic [PADW-1:0]   en_pad, ordy_pad, ovld_pad;
  logic              sop_bad, sop_dis, fwd_now, out_free, accept;
  logic              unused_user;

  // Padding to a power of two keeps variable indexing in range for any idx.
  assign idx         = egr_bus_tuser[PORT_W-1:0];
  assign en_pad      = PADW'(egr_phys_ports_enable);
  assign ordy_pad    = PADW'(egr_ports_tready);
  assign ovld_pad    = PADW'(egr_ports_tvalid);
  assign unused_user = ^egr_bus_tuser;

  always_comb begin
    sop_bad   = ({1'b0, idx} >= N_EXT);
    sop_dis   = !sop_bad && !en_pad[idx];
    cur_sel   = (state == IDLE) ? idx : sel;
    fwd_now   = (state == FWD) || ((state == IDLE) && !sop_bad && !sop_dis);
    out_free  = !ovld_pad[cur_sel] || ordy_pad[cur_sel];
    egr_bus_tready = aresetn && (fwd_now ? out_free : 1'b1);
    accept    = egr_bus_tvalid && egr_bus_tready;
    state_nxt = state;
    if (accept) begin
      if (egr_bus_tlast) begin
        state_nxt = IDLE;
      end else if (state == IDLE) begin
        state_nxt = fwd_now ? FWD : DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      if (accept && (state == IDLE) && fwd_now) begin
        sel <= idx;
      end
    end
  end

  for (genvar p = 0; p < N; p++) begin : g_port
    logic [DATA_BYTES*8-1:0] data_q;
    logic [DATA_BYTES-1:0]   keep_q;
    logic                    last_q, vld_q;
    logic [CW-1:0]           pkt_q, drop_q;
    logic                    load, drain, drop_hit;

    assign load     = accept && fwd_now && (cur_sel == PORT_W'(p));
    assign drain    = vld_q && egr_ports_tready[p];
    assign drop_hit = accept && (state == IDLE) && sop_dis && (idx == PORT_W'(p));

    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        data_q <= '0;
        keep_q <= '0;
        last_q <= 1'b0;
        vld_q  <= 1'b0;
      end else if (load) begin
        data_q <= egr_bus_tdata;
        keep_q <= egr_bus_tkeep;
        last_q <= egr_bus_tlast;
        vld_q  <= 1'b1;
      end else if (drain) begin
        vld_q  <= 1'b0;
      end
    end

    // Clear wins over a same-cycle increment; both counters saturate.
    always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
        pkt_q  <= '0;
        drop_q <= '0;
      end else if (egr_cnts_clear[p]) begin
        pkt_q  <= '0;
        drop_q <= '0;
      end else begin
        if (drain && last_q && (pkt_q != CNT_MAX)) begin
          pkt_q <= pkt_q + 1'b1;
        end
        if (drop_hit && (drop_q != CNT_MAX)) begin
          drop_q <= drop_q + 1'b1;
        end
      end
    end

    assign egr_ports_tdata[p]  = data_q;
    assign egr_ports_tkeep[p]  = keep_q;
    assign egr_ports_tlast[p]  = last_q;
    assign egr_ports_tvalid[p] = vld_q;
    assign egr_pkt_cnt[p]      = pkt_q;
    assign egr_drop_cnt[p]     = drop_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      egr_bad_port_drop_cnt <= '0;
    end else if (egr_bad_port_clear) begin
      egr_bad_port_drop_cnt <= '0;
    end else if (accept && (state == IDLE) && sop_bad &&
                 (egr_bad_port_drop_cnt != CNT_MAX)) begin
      egr_bad_port_drop_cnt <= egr_bad_port_drop_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_p4_router_egress_demux.sv
`default_nettype none
// Self-checking bench for p4_router_egress_demux: scoreboard of per-port
// beat queues and counter model driven from observed handshakes.
module tb_p4_router_egress_demux;

  localparam int NP   = 5;
  localparam int DB   = 4;
  localparam int UW   = 8;
  localparam int CW   = 4;
  localparam int DW   = DB * 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int SPAN = 8;  // ports addressable by the 3-bit index field

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] egr_bus_tdata = '0;
  logic [DB-1:0] egr_bus_tkeep = '0;
  logic [UW-1:0] egr_bus_tuser = '0;
  logic          egr_bus_tlast = 1'b0;
  logic          egr_bus_tvalid = 1'b0;
  logic          egr_bus_tready;
  logic [DW-1:0] egr_ports_tdata [NP];
  logic [DB-1:0] egr_ports_tkeep [NP];
  logic [NP-1:0] egr_ports_tlast, egr_ports_tvalid;
  logic [NP-1:0] egr_ports_tready = '1;
  logic [NP-1:0] egr_phys_ports_enable = '1;
  logic [NP-1:0] egr_cnts_clear = '0;
  logic [CW-1:0] egr_pkt_cnt [NP];
  logic [CW-1:0] egr_drop_cnt [NP];
  logic [CW-1:0] egr_bad_port_drop_cnt;
  logic          egr_bad_port_clear = 1'b0;

  p4_router_egress_demux #(
    .NUM_EGR_PHYS_PORTS(NP), .DATA_BYTES(DB), .USER_WIDTH(UW), .EGR_COUNTERS_WIDTH(CW)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .egr_bus_tdata(egr_bus_tdata), .egr_bus_tkeep(egr_bus_tkeep),
    .egr_bus_tuser(egr_bus_tuser), .egr_bus_tlast(egr_bus_tlast),
    .egr_bus_tvalid(egr_bus_tvalid), .egr_bus_tready(egr_bus_tready),
    .egr_ports_tdata(egr_ports_tdata), .egr_ports_tkeep(egr_ports_tkeep),
    .egr_ports_tlast(egr_ports_tlast), .egr_ports_tvalid(egr_ports_tvalid),
    .egr_ports_tready(egr_ports_tready), .egr_phys_ports_enable(egr_phys_ports_enable),
    .egr_cnts_clear(egr_cnts_clear), .egr_pkt_cnt(egr_pkt_cnt),
    .egr_drop_cnt(egr_drop_cnt), .egr_bad_port_drop_cnt(egr_bad_port_drop_cnt),
    .egr_bad_port_clear(egr_bad_port_clear)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [DB-1:0] k;
    logic          l;
  } beat_t;

  beat_t expq [NP][$];
  int    m_pkt [NP];
  int    m_drop [NP];
  int    m_bad;
  bit    m_in;
  int    m_kind, m_dest, m_idx;
  beat_t eb;
  bit    pinc [NP];
  bit    dinc [NP];
  bit    binc;
  int    checks = 0;
  int    errors = 0;

  // Reference model: packets go where the SOP index says, beats in order.
  always @(negedge clk) begin
    if (!aresetn) begin
      for (int p = 0; p < NP; p++) begin
        expq[p].delete();
        m_pkt[p] = 0;
        m_drop[p] = 0;
      end
      m_bad = 0;
      m_in = 1'b0;
    end else begin
      binc = 1'b0;
      for (int p = 0; p < NP; p++) begin
        pinc[p] = 1'b0;
        dinc[p] = 1'b0;
        if (egr_ports_tvalid[p] && egr_ports_tready[p]) begin
          checks++;
          if (expq[p].size() == 0) begin
            errors++;
            $display("FAIL port%0d_unexpected_beat: got data %h last %b, required no beat",
                     p, egr_ports_tdata[p], egr_ports_tlast[p]);
          end else begin
            eb = expq[p].pop_front();
            if ({egr_ports_tdata[p], egr_ports_tkeep[p], egr_ports_tlast[p]} !== eb) begin
              errors++;
              $display("FAIL port%0d_beat: got %h/%h/%b, required %h/%h/%b", p,
                       egr_ports_tdata[p], egr_ports_tkeep[p], egr_ports_tlast[p], eb.d, eb.k, eb.l);
            end
            pinc[p] = eb.l;
          end
        end
      end
      if (egr_bus_tvalid && egr_bus_tready) begin
        if (!m_in) begin
          m_idx = int'(egr_bus_tuser) % SPAN;
          if (m_idx >= NP) begin
            m_kind = 2;
            binc = 1'b1;
          end else if (!egr_phys_ports_enable[m_idx]) begin
            m_kind = 1;
            dinc[m_idx] = 1'b1;
          end else begin
            m_kind = 0;
            m_dest = m_idx;
          end
        end
        if (m_kind == 0) expq[m_dest].push_back({egr_bus_tdata, egr_bus_tkeep, egr_bus_tlast});
        m_in = !egr_bus_tlast;
      end
      for (int p = 0; p < NP; p++) begin
        if (egr_cnts_clear[p]) begin
          m_pkt[p] = 0;
          m_drop[p] = 0;
        end else begin
          if (pinc[p] && m_pkt[p] < CMAX) m_pkt[p]++;
          if (dinc[p] && m_drop[p] < CMAX) m_drop[p]++;
        end
      end
      if (egr_bad_port_clear) m_bad = 0;
      else if (binc && m_bad < CMAX) m_bad++;
    end
  end

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += expq[p].size();
    return n;
  endfunction

  task automatic drive_beat(input logic [UW-1:0] u, input logic l, inout int stalls);
    int n = 0;
    bit done = 1'b0;
    egr_bus_tdata  = DW'($urandom());
    egr_bus_tkeep  = DB'($urandom_range(1, (1 << DB) - 1));
    egr_bus_tuser  = u;
    egr_bus_tlast  = l;
    egr_bus_tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (egr_bus_tready) begin
        done = 1'b1;
      end else begin
        stalls++;
        n++;
        if (n > 200) begin
          checks++;
          errors++;
          $display("FAIL beat_accept_timeout: got no handshake in %0d cycles, required one", n);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1 egr_bus_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int user, input int len, inout int stalls);
    for (int i = 0; i < len; i++) begin
      drive_beat((i == 0) ? UW'(user) : UW'($urandom()), i == len - 1, stalls);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (pending() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, pending());
    end
    @(posedge clk);
    #2;
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (egr_pkt_cnt[p] !== CW'(m_pkt[p]) || egr_drop_cnt[p] !== CW'(m_drop[p])) begin
        errors++;
        $display("FAIL %s_cnt[%0d]: got pkt %0d drop %0d, required pkt %0d drop %0d", name, p,
                 egr_pkt_cnt[p], egr_drop_cnt[p], m_pkt[p], m_drop[p]);
      end
    end
    checks++;
    if (egr_bad_port_drop_cnt !== CW'(m_bad)) begin
      errors++;
      $display("FAIL %s_bad_cnt: got %0d, required %0d", name, egr_bad_port_drop_cnt, m_bad);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (egr_bus_tready !== 1'b0 || egr_ports_tvalid !== '0 || egr_ports_tlast !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got tready %b tvalid %b tlast %b, required all 0",
               egr_bus_tready, egr_ports_tvalid, egr_ports_tlast);
    end
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (egr_ports_tdata[p] !== '0 || egr_ports_tkeep[p] !== '0 ||
          egr_pkt_cnt[p] !== '0 || egr_drop_cnt[p] !== '0) begin
        errors++;
        $display("FAIL reset_port%0d: got data %h keep %h pkt %0d drop %0d, required all 0", p,
                 egr_ports_tdata[p], egr_ports_tkeep[p], egr_pkt_cnt[p], egr_drop_cnt[p]);
      end
    end
    @(posedge clk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_basic_steering();
    int stalls = 0;
    for (int p = 0; p < NP; p++) send_pkt(p, 3, stalls);
    checks++;
    if (egr_ports_tvalid[NP-1] !== 1'b1 || egr_ports_tlast[NP-1] !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got tvalid %b tlast %b one cycle after last beat, required 1/1",
               egr_ports_tvalid[NP-1], egr_ports_tlast[NP-1]);
    end
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL basic_throughput: got %0d stall cycles, required 0", stalls);
    end
    wait_drain("basic");
  endtask

  task automatic test_disabled_port();
    int stalls = 0;
    egr_phys_ports_enable[2] = 1'b0;
    send_pkt(2, 5, stalls);
    drive_beat(UW'(0), 1'b0, stalls);
    checks++;
    if (egr_ports_tvalid[0] !== 1'b1 || egr_ports_tvalid[2] !== 1'b0) begin
      errors++;
      $display("FAIL disabled_timing: got tvalid0 %b tvalid2 %b, required 1/0",
               egr_ports_tvalid[0], egr_ports_tvalid[2]);
    end
    drive_beat(UW'($urandom()), 1'b1, stalls);
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL disabled_throughput: got %0d stall cycles, required 0", stalls);
    end
    egr_phys_ports_enable[2] = 1'b1;
    wait_drain("disabled");
  endtask

  task automatic test_bad_and_mid_packet();
    int stalls = 0;
    send_pkt(7, 3, stalls);
    send_pkt(13, 2, stalls);
    send_pkt(9, 2, stalls);
    drive_beat(UW'(1), 1'b0, stalls);
    drive_beat(UW'(3), 1'b0, stalls);
    egr_phys_ports_enable[1] = 1'b0;
    drive_beat(UW'($urandom()), 1'b0, stalls);
    drive_beat(UW'($urandom()), 1'b1, stalls);
    egr_phys_ports_enable[1] = 1'b1;
    wait_drain("bad_mid");
  endtask

  task automatic test_backpressure();
    int stalls = 0;
    egr_ports_tready[1] = 1'b0;
    fork
      send_pkt(1, 4, stalls);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (egr_bus_tready !== 1'b0 || egr_ports_tvalid[1] !== 1'b1) begin
          errors++;
          $display("FAIL backpressure_hold: got bus tready %b port1 tvalid %b, required 0/1",
                   egr_bus_tready, egr_ports_tvalid[1]);
        end
        @(posedge clk);
        #1 egr_ports_tready[1] = 1'b1;
      end
    join
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL backpressure_stalls: got %0d stall cycles, required 3", stalls);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_single_sat_clear();
    int stalls = 0;
    for (int i = 0; i < 10; i++) send_pkt(i % 2, 1, stalls);
    wait_drain("single");
    for (int i = 0; i < 20; i++) send_pkt(0, 1, stalls);
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("FAIL single_throughput: got %0d stall cycles, required 0", stalls);
    end
    wait_drain("saturate");
    checks++;
    if (egr_pkt_cnt[0] !== CW'(CMAX)) begin
      errors++;
      $display("FAIL saturate_pkt_cnt0: got %0d, required %0d", egr_pkt_cnt[0], CMAX);
    end
    drive_beat(UW'(0), 1'b1, stalls);
    egr_cnts_clear[0] = 1'b1;
    egr_bad_port_clear = 1'b1;
    @(posedge clk);
    #1;
    egr_cnts_clear[0] = 1'b0;
    egr_bad_port_clear = 1'b0;
    #1;
    checks++;
    if (egr_pkt_cnt[0] !== '0 || egr_bad_port_drop_cnt !== '0) begin
      errors++;
      $display("FAIL clear_priority: got pkt0 %0d bad %0d, required 0/0",
               egr_pkt_cnt[0], egr_bad_port_drop_cnt);
    end
    wait_drain("clear");
  endtask

  task automatic test_random();
    int  stalls = 0;
    bit  done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          for (int p = 0; p < NP; p++) egr_phys_ports_enable[p] = ($urandom_range(0, 3) != 0);
          send_pkt($urandom_range(0, 15), $urandom_range(1, 4), stalls);
        end
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk);
        #1 egr_ports_tready = NP'($urandom());
      end
    join
    egr_ports_tready = '1;
    egr_phys_ports_enable = '1;
    wait_drain("random");
  endtask

  task automatic test_async_reset();
    int stalls = 0;
    drive_beat(UW'(3), 1'b0, stalls);
    egr_bus_tuser  = UW'($urandom());
    egr_bus_tlast  = 1'b0;
    egr_bus_tvalid = 1'b1;
    @(posedge clk);
    #3 aresetn = 1'b0;
    #1;
    checks++;
    if (egr_bus_tready !== 1'b0 || egr_ports_tvalid !== '0) begin
      errors++;
      $display("FAIL async_reset: got tready %b tvalid %b, required 0/0",
               egr_bus_tready, egr_ports_tvalid);
    end
    egr_bus_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    send_pkt(0, 2, stalls);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_steering();
    test_disabled_port();
    test_bad_and_mid_packet();
    test_backpressure();
    test_single_sat_clear();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
